// File: rtl/mem_resp_pkg.sv
// Shared types for the mem_responder slave: FSM state encoding and the captured request.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

endpackage

// File: rtl/mem_resp_ram.sv
// Word-organised storage with per-byte write enables, synchronous write and asynchronous read.
module mem_resp_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata
);

  // NOTE: the array has no reset branch; clearing it would need a per-word
  // write path and contents must survive reset anyway.
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory slave with programmable wait states and an error response.
// Optional feature: define MEM_RESP_ERRCNT_EN to add the saturating o_err_count output.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
`ifdef MEM_RESP_ERRCNT_EN
  ,
  output logic [7:0]  o_err_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  req_t        req_in, acc;
  logic        acc_err, enter_resp, ram_we;
  logic [31:0] ram_rdata;

  assign req_in = '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata, be: i_req_be};

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request rather than the not-yet-captured copy.
  assign acc     = (state_q == IDLE) ? req_in : req_q;
  assign acc_err = (acc.addr[1:0] != 2'b00) || (acc.addr[31:AW+2] != '0);

  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          req_d = req_in;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) enter_resp = 1'b1;
        else               cnt_d      = cnt_q - 4'd1;
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      state_d = RESP;
      err_d   = acc_err;
      rdata_d = (acc.we || acc_err) ? 32'd0 : ram_rdata;
    end
  end

  // A reset on the commit edge wins, so an in-flight write never lands.
  assign ram_we = enter_resp && acc.we && !acc_err && !i_reset;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  mem_resp_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_addr  (acc.addr[AW+1:2]),
    .i_wdata (acc.wdata),
    .i_be    (acc.be),
    .o_rdata (ram_rdata)
  );

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

`ifdef MEM_RESP_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_cnt_q <= 8'd0;
    end else if ((state_q == RESP) && i_rsp_ready && err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 latency instance).
// Define MEM_RESP_ERRCNT_EN to also check o_err_count.
module tb_mem_responder;

  localparam int unsigned WC = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
`ifdef MEM_RESP_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  logic        v0, rdy0, we0, rv0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned acc_cyc  = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WC)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_be    (req_be),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
`ifdef MEM_RESP_ERRCNT_EN
    ,
    .o_err_count (err_count)
`endif
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (v0),
    .o_req_ready (rdy0),
    .i_req_we    (we0),
    .i_req_addr  (addr0),
    .i_req_wdata (wdata0),
    .i_req_be    (be0),
    .o_rsp_valid (rv0),
    .i_rsp_ready (1'b1),
    .o_rsp_rdata (rdata0),
    .o_rsp_err   (err0)
`ifdef MEM_RESP_ERRCNT_EN
    ,
    .o_err_count ()
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: on each new response, pop the expectation and compare data, error and latency.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (rsp_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: response with no pending request (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        // valid is first sampled on accept edge + 1 + WC, i.e. it rises WC edges after accept
        check("rsp_latency", cyc - acc_cyc, WC);
      end
    end
    valid_prev <= rsp_valid;
  end

  // Issue one request; called at a negedge, returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                       input bit push);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL req_ready_timeout: ready never rose (t=%0t)", $time);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (push) exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || rsp_valid) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d responses outstanding (t=%0t)", exp_q.size(), $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    v0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

    // Full write, partial write, no-op write, read-backs
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0,        1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'h0,        4'b1111, 32'hDEADBEAA, 1'b0, 1'b1);
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0, 1'b1);
    issue(1'b0, 32'h10, 32'h0,        4'b0101, 32'hDEADBEAA, 1'b0, 1'b1);

    // Misaligned and out-of-range reads fault
    issue(1'b0, 32'h11,  32'h0, 4'b1111, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 32'h400, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b1);
    drain();
    @(negedge clk);
`ifdef MEM_RESP_ERRCNT_EN
    check("err_count_2", {24'd0, err_count}, 32'd2);
`endif
    issue(1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEAA, 1'b0, 1'b1);

    // Last word in range
    issue(1'b1, 32'h3FC, 32'h01020304, 4'b1111, 32'h0,        1'b0, 1'b1);
    issue(1'b0, 32'h3FC, 32'h0,        4'b1111, 32'h01020304, 1'b0, 1'b1);
    issue(1'b1, 32'h20,  32'hCAFEF00D, 4'b1111, 32'h0,        1'b0, 1'b1);
    issue(1'b0, 32'h20,  32'h0,        4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    // Back-pressure: response held while a stray write request is ignored
    rsp_ready = 1'b0;
    issue(1'b0, 32'h20, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_be = 4'b1111;
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'hCAFEF00D);
      check("stall_err", {31'd0, rsp_err}, 32'd0);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    // Reset while a write sits in WAIT: it must never commit
    issue(1'b1, 32'h20, 32'h12345678, 4'b1111, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    check("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
`ifdef MEM_RESP_ERRCNT_EN
    check("err_count_rst", {24'd0, err_count}, 32'd0);
`endif
    issue(1'b0, 32'h20, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
    drain();

    // Zero wait states: response sampled on the edge right after accept
    @(negedge clk);
    check("wc0_idle_valid", {31'd0, rv0}, 32'd0);
    v0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h55AA; be0 = 4'b1111;
    @(posedge clk);
    #1;
    check("wc0_wr_valid", {31'd0, rv0}, 32'd1);
    check("wc0_wr_err", {31'd0, err0}, 32'd0);
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    check("wc0_ready_again", {31'd0, rdy0}, 32'd1);
    v0 = 1'b1; we0 = 1'b0;
    @(posedge clk);
    #1;
    check("wc0_rd_valid", {31'd0, rv0}, 32'd1);
    check("wc0_rd_rdata", rdata0, 32'h55AA);
    @(negedge clk);
    v0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
